// File: rtl/trax_link_pkg.sv
// trax_link_pkg: shared move width and link sequencer state encoding
package trax_link_pkg;
  localparam int MOVE_W = 22;
  typedef enum logic [1:0] {SYNC, LOCAL, WAIT, ERROR} link_state_t;
endpackage

// File: rtl/trax_link_timer.sv
// trax_link_timer: reply timeout counter; ports clock/reset, clr (force to 0), en (count), tc (terminal-count pulse)
module trax_link_timer #(
  parameter int TIMEOUT_CYCLES = 50_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);
  logic [W-1:0] count;
  assign tc = en && count == LAST;
  always_ff @(posedge clock or posedge reset)
    if (reset) count <= '0;
    else count <= (clr || tc) ? '0 : en ? count + 1'b1 : count;
endmodule

// File: rtl/trax_link_sequencer.sv
// trax_link_sequencer: TRAX turn/link controller between game logic and transceiver (retry logic under TRAX_LINK_RETRY_EN)
// Ports: clock, reset (async high); local_move/local_move_valid from game; rx_move/rx_color/rx_done from transceiver;
// tx_move/tx_start to transceiver; remote_move/remote_move_valid to game; my_turn, my_color, link_error status.
module trax_link_sequencer
  import trax_link_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int MAX_RETRY      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [MOVE_W-1:0] local_move,
  input  logic              local_move_valid,
  input  logic [MOVE_W-1:0] rx_move,
  input  logic              rx_color,
  input  logic              rx_done,
  output logic [MOVE_W-1:0] tx_move,
  output logic              tx_start,
  output logic [MOVE_W-1:0] remote_move,
  output logic              remote_move_valid,
  output logic              my_turn,
  output logic              my_color,
  output logic              link_error
);
  link_state_t state, nxt;
  logic [MOVE_W-1:0] tx_move_n, rm_n;
  logic tx_start_n, rmv_n, color_n, have_remote, have_n, dup;
  assign dup = have_remote && rx_move == remote_move;
  assign my_turn = state == LOCAL;
  assign link_error = state == ERROR;
`ifdef TRAX_LINK_RETRY_EN
  localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] MAXR = RW'(MAX_RETRY);
  logic [RW-1:0] retries, retries_n;
  logic tc, tmr_clr;
  // A duplicate right after our own pulse is dropped so tx_start never fires back to back.
  assign tmr_clr = state != WAIT || (rx_done && dup && !tx_start);
  trax_link_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clock(clock),
    .reset(reset),
    .clr(tmr_clr),
    .en(state == WAIT),
    .tc(tc)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) retries <= '0;
    else retries <= retries_n;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, MAX_RETRY};
`endif
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= SYNC;
    else state <= nxt;
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      tx_move <= '0;
      tx_start <= 1'b0;
      remote_move <= '0;
      remote_move_valid <= 1'b0;
      my_color <= 1'b0;
      have_remote <= 1'b0;
    end else begin
      tx_move <= tx_move_n;
      tx_start <= tx_start_n;
      remote_move <= rm_n;
      remote_move_valid <= rmv_n;
      my_color <= color_n;
      have_remote <= have_n;
    end
  always_comb begin
    nxt = state;
    tx_move_n = tx_move;
    tx_start_n = 1'b0;
    rm_n = remote_move;
    rmv_n = 1'b0;
    color_n = my_color;
    have_n = have_remote;
`ifdef TRAX_LINK_RETRY_EN
    retries_n = retries;
`endif
    case (state)
      SYNC:
        if (rx_done) begin
          rm_n = rx_move;
          color_n = ~rx_color;
          rmv_n = 1'b1;
          have_n = 1'b1;
          nxt = LOCAL;
        end else if (local_move_valid) begin
          color_n = 1'b0;
          tx_move_n = local_move;
          tx_start_n = 1'b1;
`ifdef TRAX_LINK_RETRY_EN
          retries_n = '0;
`endif
          nxt = WAIT;
        end
      LOCAL:
        if (rx_done && !dup) nxt = ERROR;
        else if (local_move_valid) begin
          tx_move_n = local_move;
          tx_start_n = 1'b1;
`ifdef TRAX_LINK_RETRY_EN
          retries_n = '0;
`endif
          nxt = WAIT;
        end
      WAIT:
        if (rx_done && !dup) begin
          rm_n = rx_move;
          rmv_n = 1'b1;
          have_n = 1'b1;
`ifdef TRAX_LINK_RETRY_EN
          retries_n = '0;
`endif
          nxt = LOCAL;
        end
`ifdef TRAX_LINK_RETRY_EN
        else if (rx_done) tx_start_n = !tx_start;
        else if (tc) begin
          if (retries < MAXR) begin
            tx_start_n = 1'b1;
            retries_n = retries + 1'b1;
          end else nxt = ERROR;
        end
`endif
      default: ;
    endcase
  end
endmodule

// File: tb/tb_trax_link_sequencer.sv
// tb_trax_link_sequencer: randomized and directed checks of trax_link_sequencer against a behavioural model
module tb_trax_link_sequencer;
  localparam int TO = 100;
  localparam int MR = 3;
  localparam int S_SYNC = 0, S_LOCAL = 1, S_WAIT = 2, S_ERR = 3;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [21:0] local_move = '0, rx_move = '0;
  logic local_move_valid = 1'b0, rx_color = 1'b0, rx_done = 1'b0;
  logic [21:0] tx_move, remote_move;
  logic tx_start, remote_move_valid, my_turn, my_color, link_error;
  int errors = 0, checks = 0;
  int m_st;
  logic [21:0] m_txm, m_rm;
  logic m_txs, m_rmv, m_col, m_have, prev_txs;
`ifdef TRAX_LINK_RETRY_EN
  int m_retries, m_since;
`endif

  always #5 clk = ~clk;

  trax_link_sequencer #(.TIMEOUT_CYCLES(TO), .MAX_RETRY(MR)) dut (
    .clock(clk),
    .reset(reset),
    .local_move(local_move),
    .local_move_valid(local_move_valid),
    .rx_move(rx_move),
    .rx_color(rx_color),
    .rx_done(rx_done),
    .tx_move(tx_move),
    .tx_start(tx_start),
    .remote_move(remote_move),
    .remote_move_valid(remote_move_valid),
    .my_turn(my_turn),
    .my_color(my_color),
    .link_error(link_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_st = S_SYNC;
    m_txm = '0;
    m_rm = '0;
    m_txs = 1'b0;
    m_rmv = 1'b0;
    m_col = 1'b0;
    m_have = 1'b0;
`ifdef TRAX_LINK_RETRY_EN
    m_retries = 0;
    m_since = 0;
`endif
  endfunction

  function automatic void m_step(input logic lmv, input logic [21:0] lm, input logic rd,
                                 input logic [21:0] rm, input logic rc);
    logic dup;
`ifdef TRAX_LINK_RETRY_EN
    logic prev;
    prev = m_txs;
`endif
    dup = m_have && rm == m_rm;
    m_txs = 1'b0;
    m_rmv = 1'b0;
    case (m_st)
      S_SYNC:
        if (rd) begin
          m_rm = rm; m_col = !rc; m_rmv = 1'b1; m_have = 1'b1; m_st = S_LOCAL;
        end else if (lmv) begin
          m_col = 1'b0; m_txm = lm; m_txs = 1'b1; m_st = S_WAIT;
`ifdef TRAX_LINK_RETRY_EN
          m_retries = 0;
`endif
        end
      S_LOCAL:
        if (rd && !dup) m_st = S_ERR;
        else if (lmv) begin
          m_txm = lm; m_txs = 1'b1; m_st = S_WAIT;
`ifdef TRAX_LINK_RETRY_EN
          m_retries = 0;
`endif
        end
      S_WAIT:
        if (rd && !dup) begin
          m_rm = rm; m_rmv = 1'b1; m_have = 1'b1; m_st = S_LOCAL;
`ifdef TRAX_LINK_RETRY_EN
          m_retries = 0;
`endif
        end
`ifdef TRAX_LINK_RETRY_EN
        else if (rd) m_txs = !prev;
        else if (m_since == TO - 1) begin
          if (m_retries < MR) begin
            m_txs = 1'b1;
            m_retries++;
          end else m_st = S_ERR;
        end
`endif
      default: ;
    endcase
`ifdef TRAX_LINK_RETRY_EN
    m_since = m_txs ? 0 : m_since + 1;
`endif
  endfunction

  task automatic compare_all();
    check("tx_start", 32'(tx_start), 32'(m_txs));
    check("tx_move", 32'(tx_move), 32'(m_txm));
    check("remote_move_valid", 32'(remote_move_valid), 32'(m_rmv));
    check("remote_move", 32'(remote_move), 32'(m_rm));
    check("my_turn", 32'(my_turn), 32'(m_st == S_LOCAL));
    check("my_color", 32'(my_color), 32'(m_col));
    check("link_error", 32'(link_error), 32'(m_st == S_ERR));
    check("no_b2b_tx_start", 32'(tx_start && prev_txs), 0);
    prev_txs = tx_start;
  endtask

  task automatic cyc(input logic lmv, input logic [21:0] lm, input logic rd,
                     input logic [21:0] rm, input logic rc);
    local_move_valid = lmv;
    local_move = lm;
    rx_done = rd;
    rx_move = rm;
    rx_color = rc;
    @(posedge clk);
    m_step(lmv, lm, rd, rm, rc);
    #1;
    compare_all();
  endtask

  task automatic idle();
    cyc(1'b0, 22'h0, 1'b0, 22'h0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    local_move_valid = 1'b0;
    rx_done = 1'b0;
    m_reset();
    prev_txs = 1'b0;
    #3;
    check("reset_outputs", 32'({tx_start, remote_move_valid, my_turn, my_color, link_error}), 0);
    check("reset_moves", 32'(tx_move | remote_move), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [21:0] rm;
    int rate;
    do_reset();
    cyc(1'b1, 22'h12345, 1'b0, 22'h0, 1'b0);
    check("t1_tx_start", 32'(tx_start), 1);
    check("t1_tx_move", 32'(tx_move), 32'h12345);
    check("t1_my_color", 32'(my_color), 0);
    check("t1_my_turn", 32'(my_turn), 0);
    for (int i = 1; i <= 400; i++) begin
      idle();
`ifdef TRAX_LINK_RETRY_EN
      if (i == 100 || i == 200 || i == 300) begin
        check("t3_retx", 32'(tx_start), 1);
        check("t3_retx_move", 32'(tx_move), 32'h12345);
      end
      if (i == 399) check("t3_err_early", 32'(link_error), 0);
      if (i == 400) check("t3_err", 32'(link_error), 1);
`else
      if (i == 400) check("t3_no_timeout", 32'({link_error, my_turn, tx_start}), 0);
`endif
    end
    do_reset();
    cyc(1'b0, 22'h0, 1'b1, 22'h0ABCD, 1'b0);
    check("t2_rmv", 32'(remote_move_valid), 1);
    check("t2_remote", 32'(remote_move), 32'h0ABCD);
    check("t2_color", 32'(my_color), 1);
    check("t2_turn", 32'(my_turn), 1);
    idle();
    check("t2_rmv_pulse", 32'(remote_move_valid), 0);
    cyc(1'b1, 22'h00777, 1'b0, 22'h0, 1'b0);
    idle();
    cyc(1'b0, 22'h0, 1'b1, 22'h0ABCD, 1'b1);
`ifdef TRAX_LINK_RETRY_EN
    check("t4_resend", 32'(tx_start), 1);
`else
    check("t4_no_resend", 32'(tx_start), 0);
`endif
    check("t4_resend_move", 32'(tx_move), 32'h00777);
    check("t4_rmv", 32'(remote_move_valid), 0);
    check("t4_turn", 32'(my_turn), 0);
    cyc(1'b0, 22'h0, 1'b1, 22'h01111, 1'b1);
    check("t4_accept", 32'(remote_move), 32'h01111);
    check("t4_color_kept", 32'(my_color), 1);
    check("t4_turn_back", 32'(my_turn), 1);
    cyc(1'b1, 22'h05555, 1'b1, 22'h01111, 1'b0);
    check("t4_local_dup_tx", 32'(tx_start), 1);
    check("t4_local_dup_err", 32'(link_error), 0);
    idle();
    cyc(1'b0, 22'h0, 1'b1, 22'h06666, 1'b0);
    cyc(1'b1, 22'h02222, 1'b1, 22'h03333, 1'b0);
    check("t5_err", 32'(link_error), 1);
    check("t5_no_tx", 32'(tx_start), 0);
    cyc(1'b1, 22'h04444, 1'b0, 22'h0, 1'b0);
    check("t5_ignored", 32'({tx_start, my_turn}), 0);
    do_reset();
    cyc(1'b1, 22'h12345, 1'b1, 22'h0EEEE, 1'b0);
    check("t6_color", 32'(my_color), 1);
    check("t6_no_tx", 32'(tx_start), 0);
    check("t6_rmv", 32'(remote_move_valid), 1);
    for (int e = 0; e < 25; e++) begin
      do_reset();
      rate = $urandom_range(10, 300);
      for (int c = 0; c < 320; c++) begin
        rm = $urandom_range(0, 1) ? m_rm : 22'($urandom);
        cyc($urandom_range(0, 7) == 0, 22'($urandom), $urandom_range(0, rate - 1) == 0,
            rm, 1'($urandom));
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
